piso_serial_tx: RTL and testbench
=================================

Name: piso_serial_tx

Overview:
- Parallel-in, serial-out transmitter. It is the driving end of the single-bit, edge-sampled serial link whose capture side is a posedge D flip-flop chain.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then shifts it onto SO one bit per CLK rising edge.
- Frames each word with SO_VALID and SO_LAST; an optional even-parity bit may follow the data.
- Sits between a parallel producer (register or counter) and the serial capture logic.

Parameters:
- WIDTH, 8, data bits per word (legal range 1..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- EN_PARITY, 0, 1 = append one even-parity bit after the data bits.
- IDLE_LEVEL, 0, value driven on SO when no bit is being sent.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- DATA_IN  input  WIDTH  word to transmit; sampled only on an accept edge.
- LOAD_VALID  input  1  producer offers DATA_IN.
- LOAD_READY  output  1  block can accept a word this cycle (combinational).
- SO  output  1  serial data (registered).
- SO_VALID  output  1  SO carries a frame bit (registered).
- SO_LAST  output  1  the current SO bit is the final bit of the frame (registered).
- DONE  output  1  one-cycle pulse after the final bit of a frame (registered).
- BUSY  output  1  state == SHIFT.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, SO=IDLE_LEVEL, SO_VALID=0, SO_LAST=0, DONE=0, shift register=0, bit counter=0, parity accumulator=0.
- Frame length N = WIDTH + EN_PARITY.
- Counter width = clog2(N+1). It holds the number of bits remaining after the current one.
- States: IDLE and SHIFT.
- LOAD_READY = (state==IDLE) | (state==SHIFT & cnt==0). It must not depend on LOAD_VALID.
- accept = LOAD_VALID & LOAD_READY, evaluated at the rising edge.
- On accept:
  - Shift register <= DATA_IN.
  - SO <= first bit (MSB or LSB per MSB_FIRST).
  - cnt <= N-1.
  - SO_VALID <= 1.
  - SO_LAST <= (N==1).
  - state <= SHIFT.
  - Parity accumulator <= first bit.
- Latency: the first bit is on SO in the cycle immediately after the accept edge. Each bit is held for exactly one CLK period.
- In SHIFT with cnt>0, each edge:
  - Shift toward the output end.
  - SO <= next data bit. Once all data bits are sent and EN_PARITY=1, SO <= accumulated XOR of the data bits (even parity).
  - cnt <= cnt-1.
  - SO_LAST <= (cnt==1).
  - Accumulate parity over data bits only.
- In SHIFT with cnt==0 and no accept:
  - state <= IDLE, SO <= IDLE_LEVEL, SO_VALID <= 0, SO_LAST <= 0.
  - DONE <= 1 for one cycle.
- In SHIFT with cnt==0 and accept (back-to-back):
  - Load the new word exactly as for an accept from IDLE; there are no idle cycles between frames.
  - DONE <= 1 for that cycle.
- LOAD_VALID while SHIFT with cnt>0: ignored. LOAD_READY=0, and DATA_IN is not sampled. The producer must hold its data.
- DATA_IN changes outside accept edges do not affect the frame in flight.
- DONE is 0 in every cycle other than the one following a frame's final bit.
- WIDTH=1, EN_PARITY=0:
  - SO_LAST=1 together with SO_VALID on every bit.
  - LOAD_READY stays 1 throughout.
  - Continuous streaming is one word per cycle.
- Reset asserted mid-frame: outputs return to reset values immediately, and the partial frame is discarded. After RST_N rises, the first accept is possible on the next rising edge.
- SO_VALID=0 always implies SO=IDLE_LEVEL.

Decomposition:
- Shared constants file holds:
  - State encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - A clog2 constant function reused by other counter blocks.
- One natural sub-module: tx_bit_counter, a loadable down-counter with a zero flag. It is parameterised on width and has CLK/RST_N/LOAD/LOAD_VAL/DEC/CNT/ZERO.
- Shift register, parity and framing logic stay in piso_serial_tx.

Test Plan:
- WIDTH=8, MSB_FIRST=1, EN_PARITY=0: load 8'hA5 once.
  - SO = 1,0,1,0,0,1,0,1 on 8 consecutive cycles after the accept edge, with SO_VALID=1 throughout.
  - SO_LAST=1 only on the 8th bit; DONE pulses one cycle later; SO returns to 0.
- MSB_FIRST=0: load 8'h0F.
  - SO = 1,1,1,1,0,0,0,0.
  - LOAD_READY=0 during bits 1-7 and =1 during bit 8.
- Back-to-back, MSB_FIRST=1: hold LOAD_VALID=1 with 8'hFF then 8'h00.
  - 16 contiguous SO_VALID cycles: eight 1s then eight 0s.
  - DONE pulses at the cycle of the second frame's first bit and again after the 16th bit.
- EN_PARITY=1, MSB_FIRST=1: load 8'h07.
  - 9 bits: 0,0,0,0,0,1,1,1, then parity 1; SO_LAST on the 9th bit.
  - Load 8'h03: parity bit 0.
- Busy rejection, MSB_FIRST=1: start 8'hA5, then pulse LOAD_VALID with 8'h3C during bit 3.
  - Frame 8'hA5 completes unchanged, with no second frame.
- Reset mid-frame: drop RST_N during bit 4 of 8'hA5, between clock edges.
  - SO=IDLE_LEVEL, SO_VALID=0, BUSY=0 immediately without waiting for CLK.
  - After release, load 8'h81: clean frame 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/piso_serial_tx_pkg.sv
// Shared state encodings and counter sizing helper for the serial transmit path.
package piso_serial_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    // Ceiling log2, usable in localparam expressions; returns 0 for values <= 1.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_serial_tx_bit_counter.sv
// Loadable down-counter with zero flag; counts bits left in a frame.
// Load has priority over decrement; decrement saturates at zero.
module tx_bit_counter #(
    parameter int CW = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          LOAD,
    input  logic [CW-1:0] LOAD_VAL,
    input  logic          DEC,
    output logic [CW-1:0] CNT,
    output logic          ZERO
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (LOAD) begin
            cnt_d = LOAD_VAL;
        end else if (DEC && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT  = cnt_q;
    assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: first bit on SO the cycle after accept, one bit per CLK.
// LOAD_READY only in IDLE or on a frame's final bit, so frames can stream back-to-back.
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          EN_PARITY  = 1'b0,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             SO,
    output logic             SO_VALID,
    output logic             SO_LAST,
    output logic             DONE,
    output logic             BUSY
);

    localparam int N  = int'(WIDTH) + int'(EN_PARITY);
    localparam int CW = clog2_f(N + 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             so_q, so_d;
    logic             so_vld_q, so_vld_d;
    logic             so_last_q, so_last_d;
    logic             done_q, done_d;
    logic             par_q, par_d;

    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic             accept;
    logic             first_bit;
    logic [WIDTH-1:0] shifted;
    logic             next_bit;
    logic             parity_next;

    tx_bit_counter #(
        .CW (CW)
    ) u_bit_counter (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LOAD     (cnt_load),
        .LOAD_VAL (CW'(N - 1)),
        .DEC      (cnt_dec),
        .CNT      (cnt),
        .ZERO     (cnt_zero)
    );

    assign LOAD_READY = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && cnt_zero);
    assign accept     = LOAD_VALID && LOAD_READY;

    assign first_bit  = MSB_FIRST ? DATA_IN[WIDTH-1] : DATA_IN[0];
    assign shifted    = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    assign next_bit   = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
    // With parity on, cnt==1 means the bit about to go out is the parity slot.
    assign parity_next = EN_PARITY && (cnt == CW'(1));

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        so_d      = so_q;
        so_vld_d  = so_vld_q;
        so_last_d = so_last_q;
        done_d    = 1'b0;
        par_d     = par_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        if (accept) begin
            // A frame ending this cycle still reports DONE even when the next one loads.
            done_d    = (state_q == ST_SHIFT);
            state_d   = ST_SHIFT;
            sr_d      = DATA_IN;
            so_d      = first_bit;
            so_vld_d  = 1'b1;
            so_last_d = (N == 1);
            par_d     = first_bit;
            cnt_load  = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (!cnt_zero) begin
                sr_d      = shifted;
                cnt_dec   = 1'b1;
                so_last_d = (cnt == CW'(1));
                if (parity_next) begin
                    so_d = par_q;
                end else begin
                    so_d  = next_bit;
                    par_d = par_q ^ next_bit;
                end
            end else begin
                state_d   = ST_IDLE;
                so_d      = IDLE_LEVEL;
                so_vld_d  = 1'b0;
                so_last_d = 1'b0;
                done_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            so_q      <= IDLE_LEVEL;
            so_vld_q  <= 1'b0;
            so_last_q <= 1'b0;
            done_q    <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            so_q      <= so_d;
            so_vld_q  <= so_vld_d;
            so_last_q <= so_last_d;
            done_q    <= done_d;
            par_q     <= par_d;
        end
    end

    assign SO       = so_q;
    assign SO_VALID = so_vld_q;
    assign SO_LAST  = so_last_q;
    assign DONE     = done_q;
    assign BUSY     = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench: four transmitter configurations driven from a vector table plus corner sequences.
module tb_piso_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [2:0] lv;
    logic [7:0] din [3];
    logic       lv1;
    logic       din1;
    logic [3:0] so, sov, sol, dn, bsy, rdy;
    logic [3:0] idle_v;

    int n_pass;
    int n_total;

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         nbits;
        logic [8:0] bits;   // send order reads left to right, first bit at [nbits-1]
    } vec_t;

    vec_t vt [6];

    // 0: MSB-first, 1: LSB-first idling high, 2: MSB-first with parity, 3: single-bit words
    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .EN_PARITY(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
        .CLK(clk), .RST_N(rst_n), .DATA_IN(din[0]), .LOAD_VALID(lv[0]), .LOAD_READY(rdy[0]),
        .SO(so[0]), .SO_VALID(sov[0]), .SO_LAST(sol[0]), .DONE(dn[0]), .BUSY(bsy[0]));

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .EN_PARITY(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .CLK(clk), .RST_N(rst_n), .DATA_IN(din[1]), .LOAD_VALID(lv[1]), .LOAD_READY(rdy[1]),
        .SO(so[1]), .SO_VALID(sov[1]), .SO_LAST(sol[1]), .DONE(dn[1]), .BUSY(bsy[1]));

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .EN_PARITY(1'b1), .IDLE_LEVEL(1'b0)) u_par (
        .CLK(clk), .RST_N(rst_n), .DATA_IN(din[2]), .LOAD_VALID(lv[2]), .LOAD_READY(rdy[2]),
        .SO(so[2]), .SO_VALID(sov[2]), .SO_LAST(sol[2]), .DONE(dn[2]), .BUSY(bsy[2]));

    piso_serial_tx #(.WIDTH(1), .MSB_FIRST(1'b1), .EN_PARITY(1'b0), .IDLE_LEVEL(1'b0)) u_w1 (
        .CLK(clk), .RST_N(rst_n), .DATA_IN(din1), .LOAD_VALID(lv1), .LOAD_READY(rdy[3]),
        .SO(so[3]), .SO_VALID(sov[3]), .SO_LAST(sol[3]), .DONE(dn[3]), .BUSY(bsy[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_frame(input int d, input logic [7:0] data, input int nbits,
                             input logic [8:0] exp, input string tag);
        @(negedge clk);
        din[d] = data;
        lv[d]  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            if (k == 0) lv[d] = 1'b0;
            check($sformatf("%s b%0d so", tag, k), 32'(so[d]), 32'(exp[nbits-1-k]));
            check($sformatf("%s b%0d so_valid", tag, k), 32'(sov[d]), 32'd1);
            check($sformatf("%s b%0d so_last", tag, k), 32'(sol[d]), 32'(k == nbits - 1));
            check($sformatf("%s b%0d load_ready", tag, k), 32'(rdy[d]), 32'(k == nbits - 1));
            check($sformatf("%s b%0d done", tag, k), 32'(dn[d]), 32'd0);
            check($sformatf("%s b%0d busy", tag, k), 32'(bsy[d]), 32'd1);
        end
        @(negedge clk);
        check($sformatf("%s end done", tag), 32'(dn[d]), 32'd1);
        check($sformatf("%s end so_valid", tag), 32'(sov[d]), 32'd0);
        check($sformatf("%s end so", tag), 32'(so[d]), 32'(idle_v[d]));
        check($sformatf("%s end busy", tag), 32'(bsy[d]), 32'd0);
        check($sformatf("%s end load_ready", tag), 32'(rdy[d]), 32'd1);
        @(negedge clk);
        check($sformatf("%s post done", tag), 32'(dn[d]), 32'd0);
        check($sformatf("%s post so", tag), 32'(so[d]), 32'(idle_v[d]));
    endtask

    initial begin
        logic [7:0]  pat;
        logic [15:0] b2b;

        n_pass  = 0;
        n_total = 0;
        idle_v  = 4'b0010;
        rst_n   = 1'b0;
        lv      = '0;
        lv1     = 1'b0;
        din1    = 1'b0;
        for (int i = 0; i < 3; i++) din[i] = '0;

        vt[0] = '{0, 8'hA5, 8, 9'b0_1010_0101};
        vt[1] = '{1, 8'h0F, 8, 9'b0_1111_0000};
        vt[2] = '{1, 8'hA5, 8, 9'b0_1010_0101};
        vt[3] = '{2, 8'h07, 9, 9'b0000_0111_1};
        vt[4] = '{2, 8'h03, 9, 9'b0000_0011_0};
        vt[5] = '{2, 8'hA5, 9, 9'b1010_0101_0};

        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset%0d so", d), 32'(so[d]), 32'(idle_v[d]));
            check($sformatf("reset%0d so_valid", d), 32'(sov[d]), 32'd0);
            check($sformatf("reset%0d so_last", d), 32'(sol[d]), 32'd0);
            check($sformatf("reset%0d done", d), 32'(dn[d]), 32'd0);
            check($sformatf("reset%0d busy", d), 32'(bsy[d]), 32'd0);
            check($sformatf("reset%0d load_ready", d), 32'(rdy[d]), 32'd1);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame(vt[i].dut, vt[i].data, vt[i].nbits, vt[i].bits, $sformatf("vec%0d", i));
        end

        // Back-to-back FF then 00 with LOAD_VALID held high.
        b2b = 16'hFF00;
        @(negedge clk);
        din[0] = 8'hFF;
        lv[0]  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) din[0] = 8'h00;
            if (k == 8) lv[0] = 1'b0;
            check($sformatf("b2b b%0d so", k), 32'(so[0]), 32'(b2b[15-k]));
            check($sformatf("b2b b%0d so_valid", k), 32'(sov[0]), 32'd1);
            check($sformatf("b2b b%0d so_last", k), 32'(sol[0]), 32'(k == 7 || k == 15));
            check($sformatf("b2b b%0d done", k), 32'(dn[0]), 32'(k == 8));
        end
        @(negedge clk);
        check("b2b end done", 32'(dn[0]), 32'd1);
        check("b2b end so_valid", 32'(sov[0]), 32'd0);

        // Load attempt during bit 3 is ignored; A5 completes and nothing follows.
        pat = 8'hA5;
        @(negedge clk);
        din[0] = 8'hA5;
        lv[0]  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) lv[0] = 1'b0;
            check($sformatf("rej b%0d so", k), 32'(so[0]), 32'(pat[7-k]));
            check($sformatf("rej b%0d so_last", k), 32'(sol[0]), 32'(k == 7));
            if (k == 2) begin
                din[0] = 8'h3C;
                lv[0]  = 1'b1;
            end
            if (k == 3) lv[0] = 1'b0;
        end
        @(negedge clk);
        check("rej end done", 32'(dn[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rej idle%0d so_valid", k), 32'(sov[0]), 32'd0);
            check($sformatf("rej idle%0d busy", k), 32'(bsy[0]), 32'd0);
        end

        // Single-bit words streamed one per cycle.
        pat = 8'b1011_0010;
        @(negedge clk);
        din1 = pat[0];
        lv1  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("w1 b%0d so", k), 32'(so[3]), 32'(pat[k]));
            check($sformatf("w1 b%0d so_valid", k), 32'(sov[3]), 32'd1);
            check($sformatf("w1 b%0d so_last", k), 32'(sol[3]), 32'd1);
            check($sformatf("w1 b%0d load_ready", k), 32'(rdy[3]), 32'd1);
            check($sformatf("w1 b%0d done", k), 32'(dn[3]), 32'(k > 0));
            if (k < 7) din1 = pat[k+1];
            else lv1 = 1'b0;
        end
        @(negedge clk);
        check("w1 end done", 32'(dn[3]), 32'd1);
        check("w1 end so_valid", 32'(sov[3]), 32'd0);
        check("w1 end so", 32'(so[3]), 32'd0);
        @(negedge clk);
        check("w1 post done", 32'(dn[3]), 32'd0);

        // Reset dropped between edges during bit 4 of A5.
        @(negedge clk);
        din[0] = 8'hA5;
        lv[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst bit4 so", 32'(so[0]), 32'd0);
        check("rst bit4 so_valid", 32'(sov[0]), 32'd1);
        check("rst bit4 busy", 32'(bsy[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async so", 32'(so[0]), 32'd0);
        check("rst async so_valid", 32'(sov[0]), 32'd0);
        check("rst async so_last", 32'(sol[0]), 32'd0);
        check("rst async busy", 32'(bsy[0]), 32'd0);
        check("rst async load_ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 8'h81, 8, 9'b0_1000_0001, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
